// File: rtl/fsm_pc_control.sv
// PC-select control with RUN/STALL/FLUSH sequencing: resolves step-4 branches and jumps,
// holds the PC on hazard stalls, squashes wrong-path younger stages and keeps event counters.
module fsm_pc_control #(
   parameter int OPCODE_W     = 6,
   parameter int FLUSH_CYCLES = 3,
   parameter int FCNT_W       = 2,
   parameter int ENABLE_BNE   = 1,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_step_4,
   input  logic [OPCODE_W-1:0] opcode_step_4,
   input  logic                is_alu_zero_step_4,
   input  logic                is_hazzard,
   output logic [1:0]          control_mux_for_PC,
   output logic                is_load_PC,
   output logic                flush,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    redirect_cnt,
   output logic [CNT_W-1:0]    stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_STALL   = 2'b01,
      ST_FLUSH   = 2'b10,
      ST_ILLEGAL = 2'b11
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6'b000010);

   localparam logic [1:0] MUX_PC4  = 2'b00;
   localparam logic [1:0] MUX_BR   = 2'b01;
   localparam logic [1:0] MUX_JMP  = 2'b10;
   localparam logic [1:0] MUX_HOLD = 2'b11;

   localparam bit BNE_ON      = (ENABLE_BNE == 1);
   localparam bit FLUSH_MULTI = (FLUSH_CYCLES > 1);
   // The redirect cycle itself is the first flush cycle, so the counter covers the rest.
   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FLUSH_MULTI ? FCNT_W'(FLUSH_CYCLES - 2) : '0;
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   state_t             state_r;
   logic [FCNT_W-1:0]  fcnt_r;
   logic [CNT_W-1:0]   redirect_cnt_r;
   logic [CNT_W-1:0]   stall_cnt_r;
   logic [1:0]         redir_sel_s;
   logic [1:0]         mux_s;
   logic               load_s;
   logic               flush_s;

   function automatic logic [1:0] redirect_sel(
      input logic                valid,
      input logic [OPCODE_W-1:0] op,
      input logic                zero
   );
      logic [1:0] sel;
      sel = MUX_PC4;
      if (!valid) begin
         sel = MUX_PC4;
      end else if ((op == OP_BEQ) && zero) begin
         sel = MUX_BR;
      end else if (BNE_ON && (op == OP_BNE) && !zero) begin
         sel = MUX_BR;
      end else if (op == OP_J) begin
         sel = MUX_JMP;
      end else begin
         sel = MUX_PC4;
      end
      return sel;
   endfunction

   assign redir_sel_s = redirect_sel(valid_step_4, opcode_step_4, is_alu_zero_step_4);

   // Same-cycle PC mux, PC load enable and flush decode.
   always_comb begin
      mux_s   = MUX_PC4;
      load_s  = 1'b1;
      flush_s = 1'b0;
      if (rst) begin
         mux_s   = MUX_PC4;
         load_s  = 1'b0;
         flush_s = 1'b0;
      end else begin
         case (state_r)
            ST_FLUSH: begin
               mux_s   = MUX_PC4;
               load_s  = 1'b1;
               flush_s = 1'b1;
            end
            default: begin
               if (redir_sel_s != MUX_PC4) begin
                  mux_s   = redir_sel_s;
                  load_s  = 1'b1;
                  flush_s = 1'b1;
               end else if (is_hazzard) begin
                  mux_s   = MUX_HOLD;
                  load_s  = 1'b0;
                  flush_s = 1'b0;
               end else begin
                  mux_s   = MUX_PC4;
                  load_s  = 1'b1;
                  flush_s = 1'b0;
               end
            end
         endcase
      end
   end

   // State, flush down-counter and event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_RUN;
         fcnt_r         <= '0;
         redirect_cnt_r <= '0;
         stall_cnt_r    <= '0;
      end else begin
         case (state_r)
            ST_RUN, ST_STALL: begin
               if (redir_sel_s != MUX_PC4) begin
                  redirect_cnt_r <= redirect_cnt_r + CNT_W'(1'b1);
                  if (FLUSH_MULTI) begin
                     state_r <= ST_FLUSH;
                     fcnt_r  <= FLUSH_LOAD;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else if (is_hazzard) begin
                  state_r <= ST_STALL;
                  if (stall_cnt_r != CNT_MAX) begin
                     stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_FLUSH: begin
               if (fcnt_r == '0) begin
                  state_r <= ST_RUN;
               end else begin
                  fcnt_r <= fcnt_r - FCNT_W'(1'b1);
               end
            end
            default: begin
               state_r <= ST_RUN;
               fcnt_r  <= '0;
            end
         endcase
      end
   end

   assign control_mux_for_PC = mux_s;
   assign is_load_PC         = load_s;
   assign flush              = flush_s;
   assign state              = state_r;
   assign redirect_cnt       = redirect_cnt_r;
   assign stall_cnt          = stall_cnt_r;

endmodule
